// File: rtl/spad_win.sv
// ---------------------------------------------------------------------------
// spad_win -- activation scratchpad with serial fill and sliding window
//
// Holds DEPTH signed activation words. A new fill starts with `start`, after
// which serial beats are written to consecutive entries. Once every entry is
// written the block is FULL and each further beat (gated by shift_en) slides
// the window by one: the oldest word drops out and the new word enters at the
// top. A parallel load (par_we) replaces the whole window in one cycle.
// NUM_RD independent read ports return registered data one cycle after rd_en.
//
// Ports
//   sclk      in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin a new serial fill (memory contents kept)
//   shift_en  in   allow sliding-window beats while FULL
//   in_valid  in   serial word valid
//   in_data   in   serial word, DATA_DW bits
//   in_ready  out  block accepts in_data this cycle
//   par_we    in   parallel load of all entries
//   par_data  in   DATA_DW*DEPTH bits, entry i at [(i+1)*DATA_DW-1 -: DATA_DW]
//   rd_en     in   sample the read addresses
//   rd_addr   in   NUM_RD*AW bits, port k at [(k+1)*AW-1 -: AW]
//   rd_data   out  NUM_RD*DATA_DW bits of registered read data
//   rd_valid  out  rd_data is valid this cycle
//   full      out  window is FULL
//   fill_cnt  out  entries written in the current fill
// ---------------------------------------------------------------------------
module spad_win #(
  parameter int DATA_DW = 12,
  parameter int DEPTH   = 8,
  parameter int NUM_RD  = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       shift_en,
  input  logic                       in_valid,
  input  logic [DATA_DW-1:0]         in_data,
  output logic                       in_ready,
  input  logic                       par_we,
  input  logic [DATA_DW*DEPTH-1:0]   par_data,
  input  logic                       rd_en,
  input  logic [NUM_RD*AW-1:0]       rd_addr,
  output logic [NUM_RD*DATA_DW-1:0]  rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [CW-1:0]              fill_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [DATA_DW-1:0] mem [DEPTH];
  logic [DATA_DW-1:0]        rd_word [NUM_RD];

  logic beat;
  logic last_fill;

  // A beat is an accepted transfer; it loses to par_we and start, which
  // both redefine the window and so make the in-flight word meaningless.
  assign beat      = in_valid & in_ready & ~par_we & ~start;
  assign last_fill = (fill_cnt == CW'(DEPTH - 1));

  // State register.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. IDLE is left only by start or par_we; FILL moves to
  // FULL once the beat landing in the last entry has been taken.
  always_comb begin
    state_next = state;
    if (par_we) begin
      state_next = FULL;
    end else if (start) begin
      state_next = FILL;
    end else if (beat && state == FILL && last_fill) begin
      state_next = FULL;
    end
  end

  // Output logic. in_ready is forced low during reset so that no beat is
  // handshaken in a cycle whose effect is discarded anyway.
  always_comb begin
    in_ready = 1'b0;
    full     = 1'b0;
    if (!rst) begin
      in_ready = (state == FILL) || (state == FULL && shift_en);
    end
    full = (state == FULL);
  end

  // Fill counter: counts written entries during FILL and parks at DEPTH.
  // A shift in FULL leaves it at DEPTH, so it never wraps.
  always_ff @(posedge sclk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (par_we) begin
      fill_cnt <= CW'(DEPTH);
    end else if (start) begin
      fill_cnt <= '0;
    end else if (beat && state == FILL) begin
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  // Window storage. In FILL the beat lands at fill_cnt, which is always
  // below DEPTH there. In FULL the whole window slides down by one entry.
  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (par_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= par_data[i*DATA_DW +: DATA_DW];
      end
    end else if (beat) begin
      if (state == FILL) begin
        mem[fill_cnt[AW-1:0]] <= in_data;
      end else if (state == FULL) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
        mem[DEPTH-1] <= in_data;
      end
    end
  end

  // Read mux. Addresses beyond the last entry (only reachable when DEPTH is
  // not a power of two) read as zero instead of aliasing another entry.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_word[k] = '0;
      if (int'(rd_addr[k*AW +: AW]) < DEPTH) begin
        rd_word[k] = mem[rd_addr[k*AW +: AW]];
      end
    end
  end

  // Read registers sample the pre-edge memory, so a read coinciding with a
  // write or shift returns the old contents. Data holds when rd_en is low.
  always_ff @(posedge sclk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        for (int k = 0; k < NUM_RD; k++) begin
          rd_data[k*DATA_DW +: DATA_DW] <= rd_word[k];
        end
      end
    end
  end

endmodule

// File: doc/spad_win.md
SPAD_WIN -- requirements
Module: spad_win

Interface
REQ-001 SHALL provide parameter DATA_DW, default 12, the signed width of one activation word.
REQ-002 SHALL provide parameter DEPTH, default 8, the number of entries (legal range 2..64).
REQ-003 SHALL provide parameter NUM_RD, default 2, the number of independent read ports (legal range 1..4).
REQ-004 SHALL define AW = $clog2(DEPTH) and CW = $clog2(DEPTH+1).
REQ-005 SHALL have port sclk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: begin a new serial fill.
REQ-008 SHALL have port shift_en, input, 1 bit: enables sliding-window shift beats while FULL.
REQ-009 SHALL have port in_valid, input, 1 bit: the serial word is valid.
REQ-010 SHALL have port in_data, input, DATA_DW bits: the serial word (SRAM or next sample).
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-012 SHALL have port par_we, input, 1 bit: parallel load of all entries.
REQ-013 SHALL have port par_data, input, DATA_DW*DEPTH bits: entry i sits at bits [(i+1)*DATA_DW-1 -: DATA_DW].
REQ-014 SHALL have port rd_en, input, 1 bit: sample the read addresses.
REQ-015 SHALL have port rd_addr, input, NUM_RD*AW bits: port k address at bits [(k+1)*AW-1 -: AW].
REQ-016 SHALL have port rd_data, output, NUM_RD*DATA_DW bits: registered signed read data, packed like rd_addr.
REQ-017 SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-018 SHALL have port full, output, 1 bit: the state is FULL.
REQ-019 SHALL have port fill_cnt, output, CW bits: the number of entries written in the current fill.

Function
REQ-020 SHALL implement three states, IDLE, FILL and FULL, encoded in a state register.
REQ-021 SHALL transfer a beat when in_valid and in_ready are both high in the same cycle.
REQ-022 SHALL drive in_ready = (state==FILL) | (state==FULL & shift_en), combinationally, and 0 during rst.
REQ-023 SHALL, in FILL, on each beat write in_data to mem[fill_cnt] and increment fill_cnt.
REQ-024 SHALL enter FULL in the cycle after the beat that makes fill_cnt reach DEPTH; fill_cnt holds at DEPTH and never wraps.
REQ-025 SHALL, in FULL, on each beat shift the window: mem[i] <= mem[i+1] for i < DEPTH-1, mem[DEPTH-1] <= in_data; fill_cnt is unchanged.
REQ-026 SHALL ignore in_valid when in_ready is low, with no state or memory change.
REQ-027 SHALL, on start from any state, enter FILL with fill_cnt = 0 and leave mem contents unchanged.
REQ-028 SHALL, on par_we from any state, load all DEPTH entries from par_data, set fill_cnt = DEPTH and enter FULL.
REQ-029 SHALL apply priority rst > par_we > start > beat; a beat coincident with start or par_we is dropped.
REQ-030 SHALL, when rd_en is high, register mem[rd_addr_k] into rd_data port k, with 1-cycle latency.
REQ-031 SHALL hold rd_data when rd_en is low, and set rd_valid the cycle after rd_en.
REQ-032 SHALL return read-before-write data for a read coincident with a write or shift (pre-edge contents).
REQ-033 SHALL return 0 for a read address >= DEPTH (possible only when DEPTH is not a power of 2).
REQ-034 SHALL allow reads in every state; reads never block writes.

Reset
REQ-035 SHALL, while rst is high, set state = IDLE, fill_cnt = 0, every mem entry = 0, rd_data = 0 and rd_valid = 0.
REQ-036 SHALL, when rst is asserted mid-FILL or mid-shift, discard the in-flight beat, and SHALL leave IDLE only on start or par_we.

Verification
REQ-037 SHALL cover serial fill: rst, start, then 8 beats 1..8 with in_valid always high -> full=1 after the 8th beat, in_ready=0, mem[0..7] = 1..8.
REQ-038 SHALL cover the shift window: from the REQ-037 state with shift_en=1, beats 9,10 -> mem = 3..10; rd_addr {0,7} read -> rd_data {3,10} one cycle later with rd_valid=1.
REQ-039 SHALL cover backpressure: in FULL with shift_en=0 and in_valid=1 for 5 cycles -> in_ready=0 and memory unchanged.
REQ-040 SHALL cover priority: par_we, start and a beat in the same cycle -> par_data loaded, FULL, fill_cnt = 8, beat dropped.
REQ-041 SHALL cover read-during-write: in FILL, write 0x7FF to entry 3 while reading address 3 -> old value returned, then 0x7FF on the next read.
REQ-042 SHALL cover negative data and reset: load -1 (0xFFF) and read it -> signed -1; assert rst mid-FILL after 4 beats -> all outputs 0, IDLE, beats ignored until start.
